sprite_timing_sequencer: RTL
============================

# sprite_timing_sequencer

Generates the dot/scanline timebase for the PPU and drives the sprite-pipeline control strobes of the sprite handler: evaluation reset, evaluation enable, fetch enable, draw window, pixel-shift enable and flag reset. It also owns the primary OAM address counter. That counter is stepped by the sprite handler's evaluation requests and by CPU OAMADDR/OAMDATA accesses, and it is cleared during sprite fetch. It sits between the PPU register file and the sprite handler and is the single source of sprite timing.

## Interface
Parameters:
- DOTS_PER_LINE, 341, dots per scanline (0..340)
- LINES_PER_FRAME, 262, scanlines per frame (0..261)
- VBLANK_LINE, 241, first vblank line
- PRERENDER_LINE, 261, pre-render line

Ports:
- clock  in  1  system clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- clock_EN  in  1  PPU dot enable; all state advances only when high
- renderEnable  in  1  background or sprite rendering enabled
- cpuOamAddrWrite  in  1  CPU write to OAMADDR
- cpuOamAddrData  in  8  value for OAMADDR
- cpuOamDataWrite  in  1  CPU write to OAMDATA
- oamNextAttr  in  1  handler request: primary address +1
- oamNextEntry  in  1  handler request: advance to the next 4-byte entry
- dot  out  9  current dot
- scanline  out  9  current scanline
- yPosition  out  9  scanline compared against sprite Y during evaluation
- primaryAddress  out  8  primary OAM address
- spriteEvalReset, spriteEval_EN, spriteFetch_EN, drawTime, pixelShifty_EN, resetFlags, vblankStart  out  1 each  control strobes
- oddFrame  out  1  frame parity

## Operation
- Counter: dot increments from 0 to 340 and then wraps to 0 while scanline increments. Scanline wraps from 261 to 0.
- Odd-frame skip: on PRERENDER_LINE dot 339, if oddFrame=1 and renderEnable=1, the next dot is line 0 dot 0 and dot 340 is skipped. oddFrame toggles on every 261→0 transition.
- Render line: scanline 0..239 or PRERENDER_LINE. rendering = renderEnable AND render line.
- Strobes are registered. Each strobe is decoded from the next dot/scanline value, so on every clock_EN it is aligned with the dot/scanline outputs:
  - spriteEvalReset: rendering, dot 0.
  - spriteEval_EN: rendering, dots 1..320. This covers the fetch window because the handler nests its fetch logic under the evaluation enable.
  - spriteFetch_EN: rendering, dots 257..320.
  - drawTime and pixelShifty_EN: renderEnable, scanline 0..239, dots 1..256.
  - resetFlags: PRERENDER_LINE, dot 1, independent of renderEnable.
  - vblankStart: VBLANK_LINE, dot 1.
- yPosition = scanline.
- primaryAddress update, on clock_EN, highest priority first:
  1. cpuOamAddrWrite: load cpuOamAddrData.
  2. rendering and dots 257..320: load 0.
  3. rendering, dots 65..256, oamNextEntry: {addr[7:2]+1, 2'b00}. Takes priority over oamNextAttr.
  4. rendering, dots 65..256, oamNextAttr: addr+1.
  5. not rendering and cpuOamDataWrite: addr+1.
  6. Otherwise hold.
- Address arithmetic is 8-bit modulo and wraps (0xFF+1 → 0x00, entry 0xFC → 0x00).
- Handler requests outside dots 65..256, or while not rendering, are ignored.

## Timing
- Reset (asynchronous, reset_n low): dot=0, scanline=PRERENDER_LINE, oddFrame=0, primaryAddress=0, all strobes 0, yPosition=PRERENDER_LINE.
- Reset mid-operation returns the block to this state immediately. Counting resumes on the first clock_EN after release.
- Strobes and counters change only on a clock edge with clock_EN=1. With clock_EN=0, every output holds.
- A change on renderEnable takes effect on the strobes at the next clock_EN. It is sampled for the odd-frame skip at dot 339.
- The CPU address-load latency is one clock_EN: the new value is visible on the following cycle.
- Frame length is 89342 clock_EN ticks, or 89341 ticks on an odd frame with rendering enabled.

## Test plan
- Release reset, renderEnable=1, clock_EN always high: after 341 ticks, scanline=0 and dot=0, with spriteEvalReset=1 for exactly that tick.
- Scanline 10: spriteEval_EN is high on dots 1..320, spriteFetch_EN on 257..320, and drawTime/pixelShifty_EN on 1..256. yPosition=10 and primaryAddress=0 at dot 257.
- Two frames with renderEnable=1 take 89342 + 89341 ticks. The same frames with renderEnable=0 take 89342 + 89342 ticks, and no sprite strobes fire.
- Address arithmetic on line 5:
  - addr 0x05 + oamNextEntry → 0x08.
  - addr 0xFF + oamNextAttr → 0x00.
  - Entry and attr together at 0x05 → 0x08.
  - cpuOamAddrWrite 0x40 together with oamNextEntry → 0x40.
  - Dot 200 with renderEnable=0 plus a handler request → address unchanged.
- resetFlags pulses exactly at line 261 dot 1 and vblankStart exactly at line 241 dot 1. With renderEnable=0 and cpuOamDataWrite, the address steps 0x10 → 0x11.
- Hold clock_EN low for 50 cycles mid-line: all outputs frozen. Assert reset_n low at line 100 dot 150: outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sprite_timing_sequencer.sv
// Dot/scanline timebase and sprite-pipeline strobe generator for the PPU.
// Also owns the primary OAM address counter shared by the CPU and the sprite handler.
module sprite_timing_sequencer #(
    parameter int unsigned DOTS_PER_LINE   = 341,
    parameter int unsigned LINES_PER_FRAME = 262,
    parameter int unsigned VBLANK_LINE     = 241,
    parameter int unsigned PRERENDER_LINE  = 261
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clock_EN,
    input  logic       renderEnable,
    input  logic       cpuOamAddrWrite,
    input  logic [7:0] cpuOamAddrData,
    input  logic       cpuOamDataWrite,
    input  logic       oamNextAttr,
    input  logic       oamNextEntry,
    output logic [8:0] dot,
    output logic [8:0] scanline,
    output logic [8:0] yPosition,
    output logic [7:0] primaryAddress,
    output logic       spriteEvalReset,
    output logic       spriteEval_EN,
    output logic       spriteFetch_EN,
    output logic       drawTime,
    output logic       pixelShifty_EN,
    output logic       resetFlags,
    output logic       vblankStart,
    output logic       oddFrame
);

    localparam logic [8:0] LastDot     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] SkipDot     = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] LastLine    = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] VblankLine  = 9'(VBLANK_LINE);
    localparam logic [8:0] PreLine     = 9'(PRERENDER_LINE);
    // Visible lines end one post-render line before vblank (239 with NTSC timing).
    localparam logic [8:0] LastVisLine = 9'(VBLANK_LINE - 2);

    logic [8:0] dot_q, dot_d;
    logic [8:0] line_q, line_d;
    logic       odd_q, odd_d;
    logic [7:0] addr_q, addr_d;

    logic eval_reset_q, eval_reset_d;
    logic eval_en_q, eval_en_d;
    logic fetch_en_q, fetch_en_d;
    logic draw_q, draw_d;
    logic shift_en_q, shift_en_d;
    logic reset_flags_q, reset_flags_d;
    logic vblank_q, vblank_d;

    logic rendering_q;
    logic rendering_d;
    logic visible_d;
    logic clear_win;
    logic req_win;

    always_comb begin
        dot_d  = dot_q;
        line_d = line_q;
        odd_d  = odd_q;
        // Odd rendered frames drop the final dot of the pre-render line.
        if (line_q == PreLine && dot_q == SkipDot && odd_q && renderEnable) begin
            dot_d  = 9'd0;
            line_d = 9'd0;
            odd_d  = ~odd_q;
        end else if (dot_q == LastDot) begin
            dot_d = 9'd0;
            if (line_q == LastLine) begin
                line_d = 9'd0;
                odd_d  = ~odd_q;
            end else begin
                line_d = line_q + 9'd1;
            end
        end else begin
            dot_d = dot_q + 9'd1;
        end
    end

    // Strobes decode the upcoming position so they stay aligned with dot/scanline.
    always_comb begin
        visible_d     = (line_d <= LastVisLine);
        rendering_d   = renderEnable && (visible_d || line_d == PreLine);
        eval_reset_d  = rendering_d && (dot_d == 9'd0);
        eval_en_d     = rendering_d && (dot_d >= 9'd1) && (dot_d <= 9'd320);
        fetch_en_d    = rendering_d && (dot_d >= 9'd257) && (dot_d <= 9'd320);
        draw_d        = renderEnable && visible_d && (dot_d >= 9'd1) && (dot_d <= 9'd256);
        shift_en_d    = draw_d;
        reset_flags_d = (line_d == PreLine) && (dot_d == 9'd1);
        vblank_d      = (line_d == VblankLine) && (dot_d == 9'd1);
    end

    always_comb begin
        rendering_q = renderEnable && ((line_q <= LastVisLine) || line_q == PreLine);
        clear_win   = (dot_q >= 9'd257) && (dot_q <= 9'd320);
        req_win     = (dot_q >= 9'd65) && (dot_q <= 9'd256);
        addr_d      = addr_q;
        if (cpuOamAddrWrite) begin
            addr_d = cpuOamAddrData;
        end else if (rendering_q && clear_win) begin
            addr_d = 8'd0;
        end else if (rendering_q && req_win && oamNextEntry) begin
            addr_d = {addr_q[7:2] + 6'd1, 2'b00};
        end else if (rendering_q && req_win && oamNextAttr) begin
            addr_d = addr_q + 8'd1;
        end else if (!rendering_q && cpuOamDataWrite) begin
            addr_d = addr_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dot_q         <= 9'd0;
            line_q        <= PreLine;
            odd_q         <= 1'b0;
            addr_q        <= 8'd0;
            eval_reset_q  <= 1'b0;
            eval_en_q     <= 1'b0;
            fetch_en_q    <= 1'b0;
            draw_q        <= 1'b0;
            shift_en_q    <= 1'b0;
            reset_flags_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else if (clock_EN) begin
            dot_q         <= dot_d;
            line_q        <= line_d;
            odd_q         <= odd_d;
            addr_q        <= addr_d;
            eval_reset_q  <= eval_reset_d;
            eval_en_q     <= eval_en_d;
            fetch_en_q    <= fetch_en_d;
            draw_q        <= draw_d;
            shift_en_q    <= shift_en_d;
            reset_flags_q <= reset_flags_d;
            vblank_q      <= vblank_d;
        end
    end

    assign dot             = dot_q;
    assign scanline        = line_q;
    assign yPosition       = line_q;
    assign primaryAddress  = addr_q;
    assign spriteEvalReset = eval_reset_q;
    assign spriteEval_EN   = eval_en_q;
    assign spriteFetch_EN  = fetch_en_q;
    assign drawTime        = draw_q;
    assign pixelShifty_EN  = shift_en_q;
    assign resetFlags      = reset_flags_q;
    assign vblankStart     = vblank_q;
    assign oddFrame        = odd_q;

endmodule
